// File: rtl/display_7seg_mux.sv
// Multiplexed seven-segment driver: sequential double-dabble binary-to-BCD plus digit scanning.
// Optional leading-zero blanking is enabled by defining DISP_BLANK_EN.
module display_7seg_mux #(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BIN_W-1:0]  bin_i,
    output logic [DIGITS-1:0] anodo_o,
    output logic [6:0]        catodo_o,
    output logic              ovf_o,
    output logic              busy_o
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [REF_W-1:0]   ref_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         cat_q, cat_d;
    logic [3:0]         dig [DIGITS];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                                   : bcd_q[gi*4 +: 4];
            assign dig[gi] = disp_q[gi*4 +: 4];
        end
    endgenerate

    // Converter: the bit leaving the top BCD digit is a lost carry, i.e. overflow.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                shift_d  = bin_i;
                bcd_d    = '0;
                sticky_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_CONV;
            end
            S_CONV: begin
                {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                sticky_d = sticky_q | bcd_adj[BCD_W-1];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q;
                ovf_d   = sticky_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DISP_BLANK_EN
    logic [DIGITS-1:0] digit_nz;
    logic [DIGITS-1:0] keep;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            assign digit_nz[gi] = |dig[gi];
            if (gi == 0) begin : g_lsd
                assign keep[gi] = 1'b1;
            end else begin : g_upper
                assign keep[gi] = |digit_nz[DIGITS-1:gi];
            end
        end
    endgenerate
`endif

    always_comb begin
        an_d  = ~(DIGITS'(1) << idx_q);
        cat_d = ovf_q ? 7'b0111111 : seg_decode(dig[idx_q]);
`ifdef DISP_BLANK_EN
        if (!ovf_q && !keep[idx_q]) begin
            an_d  = '1;
            cat_d = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
            ref_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            cat_q    <= '1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
            an_q     <= an_d;
            cat_q    <= cat_d;
            if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
        end
    end

    assign anodo_o  = an_q;
    assign catodo_o = cat_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = (state_q != S_IDLE);
endmodule

// File: doc/display_7seg_mux.md
# display_7seg_mux

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit, 16-bit display module. It converts an unsigned binary input to BCD with a sequential double-dabble engine, then time-multiplexes DIGITS common-anode digits at a configurable refresh rate. It adds overflow detection and optional leading-zero blanking, and sits between the adder datapath and the board display pins.

## Interface
- DIGITS, 4: number of display digits (1–8).
- BIN_W, 16: width of binary input (4–32).
- REFRESH_DIV, 100000: clock cycles each digit stays active (≥2).
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- bin_i  in  BIN_W  unsigned value to display; sampled only in IDLE.
- anodo_o  out  DIGITS  digit enables, active-low, one-hot; bit 0 = least significant digit.
- catodo_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- ovf_o  out  1  high while displayed value ≥ 10^DIGITS.
- busy_o  out  1  high while a conversion is in progress.

## Operation
- Converter FSM: IDLE → CONV → DONE → IDLE, free-running.
  - IDLE, 1 cycle: capture bin_i into the shift register, clear the BCD accumulator and the sticky overflow flag, then go to CONV.
  - CONV, exactly BIN_W cycles: add 3 to each BCD digit ≥5, then shift {bcd, bin} left by 1. The bit shifted out of the top BCD digit ORs into the sticky overflow flag.
  - DONE, 1 cycle: copy the accumulator into the display register and the flag into ovf_o, then go to IDLE.
- busy_o is high in CONV and DONE.
- bin_i changes during CONV/DONE are ignored until the next IDLE.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. At its terminal count, the digit index advances modulo DIGITS: DIGITS-1 wraps to 0.
- Output stage is registered:
  - anodo_o = all ones except bit[index] = 0.
  - catodo_o = decode of display digit[index].
- Decode table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Overflow: while ovf_o=1, every digit shows dash 0111111, and the anodes scan normally.
- Arithmetic: BCD accumulator is 4·DIGITS bits and the loop counter is ceil(log2(BIN_W+1)) bits. There is no truncation other than the overflow path.

## Timing
- Reset (rst_i low, asynchronous):
  - FSM → IDLE; refresh counter, index and display register → 0.
  - anodo_o all ones, catodo_o 1111111, ovf_o 0, busy_o 0.
- First clock after release: the output register loads digit 0. anodo_o = ~1, catodo_o = 1000000.
- Conversion latency: bin_i is sampled on the IDLE edge, and the display register updates BIN_W+1 cycles later. Period is BIN_W+2 cycles.
- Output register lags index/display changes by 1 cycle.
- Each digit is active for exactly REFRESH_DIV cycles. Only one anode is low at any time, so there are no overlapping enables.
- Reset asserted mid-conversion aborts it; the partial result is never displayed.
- A display-register update coinciding with an index advance is fine: the output register picks up the new index and the new data on the same edge.

## Configuration
- DISP_BLANK_EN defined: leading-zero blanking.
  - Any digit above the most significant non-zero digit has its anode held high and cathode 1111111.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blanking is not applied while ovf_o=1.
- DISP_BLANK_EN undefined: every digit is always shown, with leading zeros as 1000000.

## Test plan
Bench uses DIGITS=4, BIN_W=16, REFRESH_DIV=4.
1. Hold rst_i=0 for 3 cycles → anodo_o=1111, catodo_o=1111111, ovf_o=0, busy_o=0. Release → next cycle anodo_o=1110, catodo_o=1000000.
2. bin_i=1234 after ≥18 cycles → scan shows, 4 cycles per digit, ovf_o=0:
   - 1110/0011001
   - 1101/0110000
   - 1011/0100100
   - 0111/1111001
3. bin_i=12345 → ovf_o=1 within 18 cycles; all four digits show 0111111. Then bin_i=9999 → ovf_o=0, all digits 0010000.
4. bin_i=7:
   - With DISP_BLANK_EN: digit 0 shows 1110/1111000, digits 1–3 show anodes high, cathode 1111111.
   - Without DISP_BLANK_EN: digits 1–3 show 1000000.
   - bin_i=0 with DISP_BLANK_EN: only digit 0 shows 1000000.
5. bin_i=5678, then change to 9999 on the 5th CONV cycle → display shows 5678 first; 9999 appears one conversion period later, and no mixed digits appear.
6. Assert rst_i on the 8th CONV cycle of 4321 while 1234 is displayed → outputs return to reset values immediately; 4321 is never shown before the next full conversion.
